// File: rtl/event_enc_pkg.sv
// Shared sizes and types for the 4-to-2 event encoder.
package event_enc_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_REQ-1:0] req_vec_t;
endpackage

// File: rtl/prio_enc4to2.sv
// Lowest-set-bit encoder over a 4-bit vector, with an any-bit-set flag.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module prio_enc4to2
    import event_enc_pkg::*;
(
    input  req_vec_t vec,
    output idx_t     idx,
    output logic     any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/event_encoder4to2.sv
// Captures event pulses into a pending register, emits one 2-bit index per transfer.
// Latency: 2 edges from req pulse to out_valid; 1 index per cycle sustained.
// Backpressure: out_idx/out_valid held while out_valid & !out_ready; events accumulate in pending.
module event_encoder4to2
    import event_enc_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  req_vec_t req,
    output logic     out_valid,
    input  logic     out_ready,
    output idx_t     out_idx,
    output req_vec_t pending,
    output logic     overflow,
    input  logic     ovf_clr
);

    idx_t                   ptr;
    idx_t                   offset;
    idx_t                   enc_idx;
    idx_t                   sel;
    logic                   enc_any;
    logic                   load;
    logic [2*N_REQ-1:0]     pend_dbl;
    req_vec_t               pend_rot;
    req_vec_t               sel_oh;
    req_vec_t               lost;

    // Round-robin searches from ptr+1 by rotating pending down, then undoing the rotation.
    assign offset   = ROUND_ROBIN ? idx_t'(ptr + 1'b1) : '0;
    assign pend_dbl = {pending, pending};
    assign pend_rot = pend_dbl[offset +: N_REQ];

    prio_enc4to2 u_prio (
        .vec (pend_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign sel    = enc_idx + offset;
    assign load   = enc_any & (~out_valid | out_ready);
    assign sel_oh = load ? (req_vec_t'(1) << sel) : '0;
    // A req landing on the bit being loaded this edge is a fresh event, not a loss.
    assign lost   = req & pending & ~sel_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
            ptr       <= idx_t'(N_REQ - 1);
        end else begin
            pending  <= (pending & ~sel_oh) | req;
            overflow <= (overflow & ~ovf_clr) | (|lost);
            if (load) begin
                out_idx   <= sel;
                out_valid <= 1'b1;
                ptr       <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_event_encoder4to2.sv
// Drives a fixed-priority and a round-robin encoder with shared stimulus and checks both
// against a per-edge behavioural model plus directed expectations.
module tb_event_encoder4to2;
    import event_enc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic       out_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic       vld_f, vld_r, ovf_f, ovf_r;
    logic [1:0] idx_f, idx_r;
    logic [3:0] pend_f, pend_r;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = fixed priority, 1 = round robin
    bit [3:0] m_pend [2];
    bit       m_vld  [2];
    int       m_idx  [2];
    int       m_ptr  [2];
    bit       m_ovf  [2];

    always #5 clk = ~clk;

    event_encoder4to2 #(.ROUND_ROBIN(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .req(req), .out_valid(vld_f), .out_ready(out_ready),
        .out_idx(idx_f), .pending(pend_f), .overflow(ovf_f), .ovf_clr(ovf_clr)
    );

    event_encoder4to2 #(.ROUND_ROBIN(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .req(req), .out_valid(vld_r), .out_ready(out_ready),
        .out_idx(idx_r), .pending(pend_r), .overflow(ovf_r), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_vld[m]  = 1'b0;
            m_idx[m]  = 0;
            m_ptr[m]  = 3;
            m_ovf[m]  = 1'b0;
        end
    endtask

    task automatic model_edge(input bit [3:0] rq, input bit rdy, input bit clr);
        for (int m = 0; m < 2; m++) begin
            bit       ld;
            bit       lost;
            int       sel;
            bit [3:0] nxt;
            sel  = -1;
            lost = 1'b0;
            if (m == 0) begin
                for (int c = 0; c < 4; c++)
                    if (sel < 0 && m_pend[m][c]) sel = c;
            end else begin
                for (int k = 1; k <= 4; k++)
                    if (sel < 0 && m_pend[m][(m_ptr[m] + k) % 4]) sel = (m_ptr[m] + k) % 4;
            end
            ld = (sel >= 0) && (!m_vld[m] || rdy);
            for (int i = 0; i < 4; i++) begin
                bit taken;
                taken  = ld && (i == sel);
                nxt[i] = (m_pend[m][i] && !taken) || rq[i];
                if (rq[i] && m_pend[m][i] && !taken) lost = 1'b1;
            end
            m_pend[m] = nxt;
            m_ovf[m]  = (m_ovf[m] && !clr) || lost;
            if (ld) begin
                m_idx[m] = sel;
                m_vld[m] = 1'b1;
                m_ptr[m] = sel;
            end else if (m_vld[m] && rdy) begin
                m_vld[m] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("fix_valid",    vld_f,  m_vld[0]);
        chk("fix_idx",      idx_f,  m_idx[0]);
        chk("fix_pending",  pend_f, m_pend[0]);
        chk("fix_overflow", ovf_f,  m_ovf[0]);
        chk("rr_valid",     vld_r,  m_vld[1]);
        chk("rr_idx",       idx_r,  m_idx[1]);
        chk("rr_pending",   pend_r, m_pend[1]);
        chk("rr_overflow",  ovf_r,  m_ovf[1]);
    endtask

    task automatic step(input logic [3:0] rq, input logic rdy, input logic clr);
        req       = rq;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        model_edge(rq, rdy, clr);
        #1;
        req     = '0;
        ovf_clr = 1'b0;
        compare_all();
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset_valid",    vld_f,  1'b0);
        chk("reset_idx",      idx_f,  2'd0);
        chk("reset_pending",  pend_r, 4'd0);
        chk("reset_overflow", ovf_r,  1'b0);
        #10 rst_n = 1'b1;

        // single event: valid exactly two edges after the pulse edge
        step(4'b0100, 1'b1, 1'b0);
        chk("single_pend_e0", pend_f, 4'b0100);
        chk("single_vld_e0",  vld_f,  1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk("single_vld_e1",  vld_f,  1'b1);
        chk("single_idx_e1",  idx_f,  2'd2);
        chk("single_pend_e1", pend_f, 4'b0000);
        step(4'b0000, 1'b1, 1'b0);
        chk("single_vld_e2",  vld_f,  1'b0);

        // all four lines: RR (last delivered 2) gives 3,0,1,2; fixed gives 0,1,2,3
        step(4'b1111, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_r;
            logic [1:0] exp_f;
            exp_r = 2'(k + 3);
            exp_f = 2'(k);
            step(4'b0000, 1'b1, 1'b0);
            chk("rr_order_vld", vld_r, 1'b1);
            chk("rr_order_idx", idx_r, exp_r);
            chk("fix_all_idx",  idx_f, exp_f);
        end
        step(4'b0000, 1'b1, 1'b0);
        chk("rr_order_done", vld_r, 1'b0);

        // fixed priority on 1011: 0,1,3 back to back
        step(4'b1011, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            logic [3:0] seq;
            seq = 4'b1011;
            step(4'b0000, 1'b1, 1'b0);
            chk("fix_multi_vld", vld_f, 1'b1);
            chk("fix_multi_idx", idx_f, (k == 2) ? 2'd3 : 2'(k));
            chk("fix_multi_src", seq[idx_f], 1'b1);
        end
        step(4'b0000, 1'b1, 1'b0);
        chk("fix_multi_done", vld_f, 1'b0);

        // backpressure: second pulse after the load is a new event, third one is lost
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("bp_load_vld",  vld_f,  1'b1);
        chk("bp_load_pend", pend_f, 4'b0000);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        chk("bp_hold_idx",  idx_f,  2'd1);
        chk("bp_hold_vld",  vld_f,  1'b1);
        chk("bp_no_ovf",    ovf_f,  1'b0);
        chk("bp_pend2",     pend_f, 4'b0010);
        step(4'b0010, 1'b0, 1'b0);
        chk("bp_ovf_set",   ovf_f,  1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk("bp_ovf_clr",   ovf_f,  1'b0);
        step(4'b0010, 1'b0, 1'b1);
        chk("bp_set_wins",  ovf_r,  1'b1);

        // asynchronous reset between edges with pending=0110 and out_valid=1
        step(4'b0100, 1'b0, 1'b0);
        chk("ar_pre_pend", pend_f, 4'b0110);
        chk("ar_pre_vld",  vld_f,  1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar_vld",  vld_f,  1'b0);
        chk("ar_pend", pend_f, 4'b0000);
        chk("ar_ovf",  ovf_f,  1'b0);
        chk("ar_idx",  idx_r,  2'd0);
        chk("ar_vld_r", vld_r, 1'b0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 1'b1, 1'b0);
            chk("ar_quiet", {vld_f, vld_r}, 2'b00);
        end

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [3:0] rq;
            rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            step(rq, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_encoder4to2.md
# event_encoder4to2

Registered 4-to-2 event encoder: the inverse direction of the team's 2-to-4 line decoder. It captures single-cycle event pulses on four one-hot-style request lines into a pending register. It encodes one pending event per transfer into a 2-bit index and delivers it on a valid/ready output port. It sits between interrupt/event sources and any consumer that re-expands the index with the 2-to-4 decoder.

## Interface
- `ROUND_ROBIN`, default 0: selection policy. 0 = fixed priority, lowest index wins; 1 = round-robin.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  4  event pulses; each bit high for one cycle = one event on that line.
- `out_valid`  out  1  `out_idx` holds an encoded event.
- `out_ready`  in  1  consumer accepts; a transfer occurs on an edge where `out_valid & out_ready`.
- `out_idx`  out  2  encoded line number 0..3.
- `pending`  out  4  captured, not-yet-encoded events (register value).
- `overflow`  out  1  sticky; an event was lost.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- **Load condition.** `load = (pending != 0) & (!out_valid | out_ready)`.
- **Selection.** Selection uses only the registered `pending`; same-cycle `req` is never selected directly.
  - Fixed mode: select the lowest set bit.
  - RR mode: search begins at `ptr+1` and wraps 3→0. `ptr` updates to the selected index on every load.
- **Pending update.** `pending_next = (pending & ~sel_onehot_if_load) | req`.
- **Output update.** On load: `out_idx <= sel`, `out_valid <= 1`.
  - On a transfer without load: `out_valid <= 0`, and `out_idx` holds its value.
  - While `out_valid & !out_ready`: `out_idx` and `out_valid` are stable.
- **Overflow.** Set when `req[i] & pending[i]` and bit i is not being cleared by a load this edge.
  - `req[i]` on the bit being loaded this edge re-sets `pending[i]`. This is a new event and not an overflow.
  - `overflow_next = (overflow & ~ovf_clr) | lost_event`. Set wins over a simultaneous clear.
- **Multiple events.** Multiple `req` bits in one cycle are all captured. They are then encoded one per load, in policy order.
- **Reset values.** `pending=0`, `out_valid=0`, `out_idx=0`, `overflow=0`, `ptr=3` (first RR search starts at 0).

## Timing
- **Latency.** `req[i]` high at edge E0 → `pending[i]=1` after E0. At E1, if the slot is free, `out_valid=1` with `out_idx=i` and `pending[i]=0`.
  - Minimum latency is 2 edges from request to `out_valid`.
- **Throughput.** 1 index per cycle under continuous `out_ready`. Reload occurs on the same edge as a transfer, so `out_valid` stays high with no bubble.
- **Ready independence.** `out_ready` may toggle at any time. `out_valid` never depends combinationally on `out_ready`; all outputs are registered.
- **Reset mid-operation.** Asserting `rst_n` low clears all state immediately (asynchronous). Pending events are discarded. The first load after deassertion needs a fresh `req`.
- **Overflow visibility.** `overflow` rises on the edge after the losing `req`.

## Structure
- **Shared package** `event_enc_pkg`:
  - `N_REQ=4`, `IDX_W=2`.
  - `typedef logic [IDX_W-1:0] idx_t`.
  - `typedef logic [N_REQ-1:0] req_vec_t`.
- **Sub-module** `prio_enc4to2`: combinational lowest-set-bit encoder with `any` flag.
  - RR mode rotates `pending` right by `ptr+1`, encodes it, then adds `ptr+1` mod 4.
- **Top level.** Holds the pending, output, pointer and overflow registers.

## Test plan
- **Single event.** Reset, `out_ready=1`, pulse `req=4'b0100` one cycle → `out_valid` high exactly 2 edges later with `out_idx=2`, for 1 cycle; `pending` returns to 0.
- **Multiple events, fixed mode.** Fixed mode, pulse `req=4'b1011`, `out_ready=1` → indices 0,1,3 on consecutive cycles with no bubbles, then `out_valid=0`.
- **Round-robin order.** RR mode, after a 2 is delivered, pulse `req=4'b1111` → order 3,0,1,2.
- **Backpressure and overflow.** `out_ready=0`, pulse `req[1]` twice, 3 cycles apart.
  - `out_idx=1` is held stable and `pending[1]` is 0 after the load, so there is no overflow.
  - A third pulse while `pending[1]=1` sets `overflow`.
  - `ovf_clr` then clears it; `ovf_clr` coincident with a new loss leaves it at 1.
- **Asynchronous reset.** Assert `rst_n=0` mid-stream, between clock edges, with `pending=4'b0110` and `out_valid=1` → all outputs 0 immediately. After deassertion, no output appears without a new `req`.
